// File: rtl/request_dispatcher_if.sv
// request_dispatcher_if: request, per-target dispatch, error response, flush and counter signals of request_dispatcher
// Ports: master drives in_*, out_ready, err_ready, flush; slave drives in_ready, out_*, err_*, dispatch_count
interface request_dispatcher_if #(
   parameter int NUM_TARGETS = 2,
   parameter int XLEN = 32,
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
);
   logic in_valid;
   logic in_ready;
   logic [2:0] in_funct3;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [REG_BITS-1:0] in_rd;
   logic [NUM_TARGETS-1:0] out_valid;
   logic [NUM_TARGETS-1:0] out_ready;
   logic [2:0] out_funct3;
   logic [XLEN-1:0] out_rs1;
   logic [XLEN-1:0] out_rs2;
   logic [REG_BITS-1:0] out_rd;
   logic err_valid;
   logic err_ready;
   logic [REG_BITS-1:0] err_rd;
   logic flush;
   logic [NUM_TARGETS*CNT_BITS-1:0] dispatch_count;
   modport master (
      output in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready, err_ready, flush,
      input in_ready, out_valid, out_funct3, out_rs1, out_rs2, out_rd, err_valid, err_rd, dispatch_count
   );
   modport slave (
      input in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready, err_ready, flush,
      output in_ready, out_valid, out_funct3, out_rs1, out_rs2, out_rd, err_valid, err_rd, dispatch_count
   );
endinterface

// File: rtl/request_dispatcher.sv
// request_dispatcher: 2-entry in-order request FIFO routing each head request by funct3 to one target or to the error port
// Ports: clk; rst (async, active-high); bus (slave) carrying in_* request, out_* one-hot dispatch, err_* illegal response, flush, dispatch_count
module request_dispatcher #(
   parameter int NUM_TARGETS = 2,
   parameter int XLEN = 32,
   parameter int REG_BITS = 5,
   parameter logic [31:0] ROUTE_MAP = 32'hFFFF_F110,
   parameter int CNT_BITS = 16
) (
   input logic clk,
   input logic rst,
   request_dispatcher_if.slave bus
);
   logic [2:0] f_q [2];
   logic [XLEN-1:0] rs1_q [2];
   logic [XLEN-1:0] rs2_q [2];
   logic [REG_BITS-1:0] rd_q [2];
   logic head, tail;
   logic [1:0] cnt;
   logic [3:0] route;
   logic legal, busy, push, pop;
   logic [NUM_TARGETS-1:0] fire;
   logic [NUM_TARGETS-1:0][CNT_BITS-1:0] cnt_q;

   // busy: a head entry exists and may be offered downstream this cycle
   assign busy = cnt != 2'd0 && !bus.flush;
   assign route = ROUTE_MAP[{f_q[head], 2'b00} +: 4];
   assign legal = route < 4'(NUM_TARGETS);
   // in_ready depends only on occupancy plus the reset/flush inhibits, never on downstream ready
   assign bus.in_ready = !rst && !bus.flush && cnt != 2'd2;
   assign bus.out_valid = busy && legal ? NUM_TARGETS'(1) << route : '0;
   assign bus.err_valid = busy && !legal;
   assign bus.out_funct3 = f_q[head];
   assign bus.out_rs1 = rs1_q[head];
   assign bus.out_rs2 = rs2_q[head];
   assign bus.out_rd = rd_q[head];
   assign bus.err_rd = rd_q[head];
   assign bus.dispatch_count = cnt_q;
   assign fire = bus.out_valid & bus.out_ready;
   assign push = bus.in_valid && bus.in_ready;
   assign pop = |fire || (bus.err_valid && bus.err_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= 1'b0;
         tail <= 1'b0;
         cnt <= 2'd0;
      end else if (bus.flush) begin
         head <= 1'b0;
         tail <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (push) tail <= ~tail;
         if (pop) head <= ~head;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         f_q[tail] <= bus.in_funct3;
         rs1_q[tail] <= bus.in_rs1;
         rs2_q[tail] <= bus.in_rs2;
         rd_q[tail] <= bus.in_rd;
      end
   end

   // counters saturate at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else
         for (int t = 0; t < NUM_TARGETS; t++)
            if (fire[t] && cnt_q[t] != '1) cnt_q[t] <= cnt_q[t] + CNT_BITS'(1);
   end
endmodule
